ahb_arbiter: RTL and testbench

Round-robin bus arbiter that shares the single-slave AHB segment (SSP/CRC register slave) between up to four AHB masters. It samples per-master bus requests and lock requests, tracks the current owner's burst so that fixed-length bursts are never split, and drives one-hot HGRANT, the address-phase owner index HMASTER and HMASTLOCK to the master/address multiplexer. Grants move only at transfer boundaries (HREADY high).

---
 rtl/ahb_arbiter_if.sv | 27 ++
 rtl/ahb_arbiter.sv | 123 ++++++++++++
 tb/tb_ahb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// Arbiter-side bus bundle: request/lock inputs, muxed owner transfer
// information and slave response in; grant, owner index and lock out.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic                   HRESP;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [1:0]             HMASTER;
    logic                   HMASTLOCK;

    // Requesting side: masters plus the muxed address/response path.
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter side.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter for 2..4 masters. Fixed-length bursts and locked
// sequences are never split; grants move only at transfer boundaries.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input logic          HCLK,
    input logic          RESET,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef logic [NUM_MASTERS-1:0] mvec_t;

    // One-hot (padded to 4 bits) to index.
    function automatic logic [1:0] enc(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    mvec_t       grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  master_q;
    logic        mastlock_q;
    logic [4:0]  cnt_q, cnt_d;
    logic        lock_q, lock_d;

    htrans_e     trans;
    logic [4:0]  burst_len;
    logic [3:0]  lock4;
    logic        owner_lock;
    logic        arb_point;
    mvec_t       hi_mask, pick, win_oh;

    assign trans      = htrans_e'(bus.HTRANS);
    assign lock4      = 4'(bus.HLOCK);
    assign owner_lock = lock4[master_q];

    // Remaining beats implied by the burst type of a NONSEQ transfer.
    always_comb begin
        burst_len = '0;
        case (bus.HBURST)
            3'b010, 3'b011: burst_len = 5'd3;
            3'b100, 3'b101: burst_len = 5'd7;
            3'b110, 3'b111: burst_len = 5'd15;
            default:        burst_len = '0;
        endcase
    end

    // Beat counter update; an error response terminates the burst.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.HRESP) begin
            cnt_d = '0;
        end else if (bus.HREADY) begin
            case (trans)
                TR_NONSEQ: cnt_d = burst_len;
                TR_SEQ:    if (cnt_q != '0) cnt_d = cnt_q - 5'd1;
                TR_IDLE:   cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    // Lock-hold flag follows the owner's HLOCK across its active transfers.
    always_comb begin
        lock_d = lock_q;
        if (bus.HREADY) begin
            if (trans == TR_NONSEQ || trans == TR_SEQ) begin
                lock_d = owner_lock;
            end else if (trans == TR_IDLE || !owner_lock) begin
                lock_d = 1'b0;
            end
        end
    end

    // Round-robin pick: requests above the pointer first, then wrap from 0
    // up to and including the pointer, so the last winner is searched last.
    always_comb begin
        hi_mask   = ~((mvec_t'(2) << last_q) - mvec_t'(1));
        pick      = ((bus.HBUSREQ & hi_mask) != '0) ? (bus.HBUSREQ & hi_mask) : bus.HBUSREQ;
        win_oh    = pick & (~pick + mvec_t'(1));
        arb_point = bus.HREADY && (cnt_d == '0) && !lock_d;
        grant_d   = grant_q;
        last_d    = last_q;
        if (arb_point) begin
            if (bus.HBUSREQ != '0) begin
                grant_d = win_oh;
                last_d  = enc(4'(win_oh));
            end else begin
                grant_d = mvec_t'(1);
            end
        end
    end

    // Arbitration state; owner index and lock advance only on HREADY.
    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            grant_q    <= mvec_t'(1);
            last_q     <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            if (bus.HREADY) begin
                master_q   <= enc(4'(grant_q));
                mastlock_q <= |(bus.HLOCK & grant_q);
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a 2-master and a 3-master instance.
module tb_ahb_arbiter;
    logic HCLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_if #(.NUM_MASTERS(2)) b2 ();
    ahb_arbiter_if #(.NUM_MASTERS(3)) b3 ();

    ahb_arbiter #(.NUM_MASTERS(2)) u2 (.HCLK(HCLK), .RESET(RESET), .bus(b2));
    ahb_arbiter #(.NUM_MASTERS(3)) u3 (.HCLK(HCLK), .RESET(RESET), .bus(b3));

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET = 1'b0;
        b2.HBUSREQ = '0; b2.HLOCK = '0; b2.HTRANS = 2'b00; b2.HBURST = 3'b000;
        b2.HREADY = 1'b1; b2.HRESP = 1'b0;
        b3.HBUSREQ = '0; b3.HLOCK = '0; b3.HTRANS = 2'b00; b3.HBURST = 3'b000;
        b3.HREADY = 1'b1; b3.HRESP = 1'b0;
        repeat (2) tick();
        chk("rst_grant2", 4'(b2.HGRANT), 4'h1);
        chk("rst_master2", 4'(b2.HMASTER), 4'h0);
        chk("rst_mlock2", 4'(b2.HMASTLOCK), 4'h0);
        chk("rst_grant3", 4'(b3.HGRANT), 4'h1);
        RESET = 1'b1;
        tick();
        chk("idle_grant", 4'(b2.HGRANT), 4'h1);

        // Contention, NUM_MASTERS=2, pointer at 0
        b2.HBUSREQ = 2'b11;
        tick();
        chk("cont_g1", 4'(b2.HGRANT), 4'h2);
        chk("cont_m1", 4'(b2.HMASTER), 4'h0);
        tick();
        chk("cont_g2", 4'(b2.HGRANT), 4'h1);
        chk("cont_m2", 4'(b2.HMASTER), 4'h1);
        b2.HBUSREQ = 2'b00;
        tick();
        chk("cont_g3", 4'(b2.HGRANT), 4'h1);
        chk("cont_m3", 4'(b2.HMASTER), 4'h0);

        // INCR4 by master 0, two wait states on beat 2, master 1 requesting
        b2.HBUSREQ = 2'b01; b2.HTRANS = 2'b10; b2.HBURST = 3'b011;
        tick();
        chk("burst_nseq", 4'(b2.HGRANT), 4'h1);
        b2.HBUSREQ = 2'b11; b2.HTRANS = 2'b11; b2.HREADY = 1'b0;
        tick();
        chk("burst_w1", 4'(b2.HGRANT), 4'h1);
        tick();
        chk("burst_w2", 4'(b2.HGRANT), 4'h1);
        b2.HREADY = 1'b1;
        tick();
        chk("burst_b2", 4'(b2.HGRANT), 4'h1);
        tick();
        chk("burst_b3", 4'(b2.HGRANT), 4'h1);
        tick();
        chk("burst_b4", 4'(b2.HGRANT), 4'h2);

        // Locked SINGLE transfers by master 1, master 0 requesting
        b2.HBUSREQ = 2'b10; b2.HLOCK = 2'b10; b2.HTRANS = 2'b00; b2.HBURST = 3'b000;
        tick();
        chk("lock_own", 4'(b2.HMASTER), 4'h1);
        chk("lock_ml0", 4'(b2.HMASTLOCK), 4'h1);
        b2.HBUSREQ = 2'b11; b2.HTRANS = 2'b10;
        tick();
        chk("lock_g1", 4'(b2.HGRANT), 4'h2);
        chk("lock_ml1", 4'(b2.HMASTLOCK), 4'h1);
        tick();
        chk("lock_g2", 4'(b2.HGRANT), 4'h2);
        chk("lock_ml2", 4'(b2.HMASTLOCK), 4'h1);
        b2.HBUSREQ = 2'b01; b2.HLOCK = 2'b00; b2.HTRANS = 2'b00;
        tick();
        chk("lock_rel", 4'(b2.HGRANT), 4'h1);
        chk("lock_ml3", 4'(b2.HMASTLOCK), 4'h0);

        // Undefined-length INCR: grant may move after the first beat
        tick();
        chk("incr_own", 4'(b2.HMASTER), 4'h0);
        b2.HBUSREQ = 2'b11; b2.HTRANS = 2'b10; b2.HBURST = 3'b001;
        tick();
        chk("incr_g", 4'(b2.HGRANT), 4'h2);
        b2.HBUSREQ = 2'b10; b2.HLOCK = 2'b10; b2.HTRANS = 2'b00;

        // Error abort of INCR8, NUM_MASTERS=3, master 2 requesting
        b3.HBUSREQ = 3'b001; b3.HTRANS = 2'b10; b3.HBURST = 3'b101;
        tick();
        chk("err_nseq", 4'(b3.HGRANT), 4'h1);
        b3.HBUSREQ = 3'b101; b3.HTRANS = 2'b11;
        tick();
        chk("err_b2", 4'(b3.HGRANT), 4'h1);
        tick();
        chk("err_b3", 4'(b3.HGRANT), 4'h1);
        b3.HRESP = 1'b1; b3.HREADY = 1'b0;
        tick();
        chk("err_wait", 4'(b3.HGRANT), 4'h1);
        b3.HREADY = 1'b1;
        tick();
        chk("err_g", 4'(b3.HGRANT), 4'h4);
        b3.HRESP = 1'b0; b3.HTRANS = 2'b00; b3.HBUSREQ = 3'b100;
        tick();
        chk("err_m", 4'(b3.HMASTER), 4'h2);
        chk("park_m2", 4'(b2.HMASTER), 4'h1);
        chk("park_ml2", 4'(b2.HMASTLOCK), 4'h1);

        // Asynchronous reset between clock edges
        #1 RESET = 1'b0;
        #1;
        chk("arst_g2", 4'(b2.HGRANT), 4'h1);
        chk("arst_m2", 4'(b2.HMASTER), 4'h0);
        chk("arst_ml2", 4'(b2.HMASTLOCK), 4'h0);
        chk("arst_g3", 4'(b3.HGRANT), 4'h1);
        chk("arst_m3", 4'(b3.HMASTER), 4'h0);
        b2.HBUSREQ = '0; b2.HLOCK = '0;
        b3.HBUSREQ = '0;
        tick();
        RESET = 1'b1;
        repeat (2) tick();
        chk("post_rst_g2", 4'(b2.HGRANT), 4'h1);
        chk("post_rst_g3", 4'(b3.HGRANT), 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
